seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier.sv | 140 ++++++++++++++
 tb/tb_seq_multiplier.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Purpose  : Iterative unsigned/signed multiplier with valid/ready on both
//            sides. It retires BITS_PER_CYCLE multiplier bits per clock.
//            Optional early termination: define SEQ_MULT_EARLY_TERM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int PARALLELISM    = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PARALLELISM-1:0]     multiplier,
    input  logic [PARALLELISM-1:0]     multiplicand,
    input  logic                       signed_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*PARALLELISM-1:0]   product
);

    localparam int c_iters = PARALLELISM / BITS_PER_CYCLE;
    localparam int c_cnt_w = (c_iters > 1) ? $clog2(c_iters) : 1;
    localparam int c_prod_w = 2 * PARALLELISM;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [PARALLELISM-1:0]   r_rem;
    logic [c_prod_w-1:0]      r_mcand_sh;
    logic [c_prod_w-1:0]      r_acc;
    logic [c_prod_w-1:0]      r_product;
    logic                     r_neg;
    logic [c_cnt_w-1:0]       r_iter;

    logic                     w_accept;
    logic [PARALLELISM-1:0]   w_a_mag;
    logic [PARALLELISM-1:0]   w_b_mag;
    logic [c_prod_w-1:0]      w_digit;
    logic [c_prod_w-1:0]      w_partial;
    logic [c_prod_w-1:0]      w_acc_next;
    logic [PARALLELISM-1:0]   w_rem_next;
    logic                     w_cnt_last;
    logic                     w_last;

    assign w_accept = (r_state == S_IDLE) && in_valid;

    // Unary minus of the most negative value yields 2^(P-1), which is the
    // correct unsigned magnitude in P bits.
    assign w_a_mag = (signed_mode && multiplier[PARALLELISM-1])   ? -multiplier   : multiplier;
    assign w_b_mag = (signed_mode && multiplicand[PARALLELISM-1]) ? -multiplicand : multiplicand;

    assign w_digit    = {{(c_prod_w-BITS_PER_CYCLE){1'b0}}, r_rem[BITS_PER_CYCLE-1:0]};
    assign w_partial  = r_mcand_sh * w_digit;
    assign w_acc_next = r_acc + w_partial;
    assign w_rem_next = r_rem >> BITS_PER_CYCLE;
    assign w_cnt_last = (r_iter == c_cnt_w'(c_iters - 1));

`ifdef SEQ_MULT_EARLY_TERM_EN
    assign w_last = w_cnt_last || (w_rem_next == '0);
`else
    assign w_last = w_cnt_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The multiplicand is pre-shifted each iteration so the k*BITS_PER_CYCLE
    // alignment never needs a variable shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem      <= '0;
            r_mcand_sh <= '0;
            r_acc      <= '0;
            r_product  <= '0;
            r_neg      <= 1'b0;
            r_iter     <= '0;
        end else if (w_accept) begin
            r_rem      <= w_a_mag;
            r_mcand_sh <= {{PARALLELISM{1'b0}}, w_b_mag};
            r_acc      <= '0;
            r_neg      <= signed_mode & (multiplier[PARALLELISM-1] ^ multiplicand[PARALLELISM-1]);
            r_iter     <= '0;
        end else if (r_state == S_BUSY) begin
            r_acc      <= w_acc_next;
            r_rem      <= w_rem_next;
            r_mcand_sh <= r_mcand_sh << BITS_PER_CYCLE;
            r_iter     <= r_iter + c_cnt_w'(1);
            if (w_last) begin
                r_product <= r_neg ? -w_acc_next : w_acc_next;
            end
        end
    end

    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier
// Purpose  : Directed self-checking bench for seq_multiplier (P=8/B=1 and
//            P=16/B=4 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

`ifdef SEQ_MULT_EARLY_TERM_EN
    localparam bit c_et = 1'b1;
`else
    localparam bit c_et = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv8 = 1'b0, or8 = 1'b0, s8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        rdy8, ov8;
    logic [15:0] p8;

    logic        iv16 = 1'b0, or16 = 1'b0, s16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        rdy16, ov16;
    logic [31:0] p16;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.PARALLELISM(8), .BITS_PER_CYCLE(1)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8),
        .multiplier(a8), .multiplicand(b8), .signed_mode(s8),
        .out_valid(ov8), .out_ready(or8), .product(p8)
    );

    seq_multiplier #(.PARALLELISM(16), .BITS_PER_CYCLE(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16),
        .multiplier(a16), .multiplicand(b16), .signed_mode(s16),
        .out_valid(ov16), .out_ready(or16), .product(p16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] exp, input int lat_exp);
        int lat;
        a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
        check({tag, "_rdy"}, rdy8, 1);
        tick();
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, lat_exp);
        check({tag, "_prod"}, p8, exp);
    endtask

    task automatic retire8(input string tag);
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        check({tag, "_rdy_after_retire"}, rdy8, 1);
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [31:0] exp, input int lat_exp);
        int lat;
        a16 = a; b16 = b; s16 = s; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        lat = 0;
        while (!ov16 && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, lat_exp);
        check({tag, "_prod"}, p16, exp);
        or16 = 1'b1;
        tick();
        or16 = 1'b0;
    endtask

    initial begin
        int acc_cyc[$];
        int guard;

        repeat (3) tick();
        rst = 1'b0;
        check("reset_rdy8",  rdy8, 1);
        check("reset_ov8",   ov8,  0);
        check("reset_p8",    p8,   16'h0000);
        check("reset_p16",   p16,  32'h0);

        // Unsigned and signed directed vectors
        run8("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 8);
        retire8("u255x255");
        run8("s_m128sq", 8'h80, 8'h80, 1'b1, 16'h4000, 8);
        retire8("s_m128sq");
        run8("s_m3x5",   8'hFD, 8'h05, 1'b1, 16'hFFF1, c_et ? 2 : 8);
        retire8("s_m3x5");
        run8("s_127xm1", 8'h7F, 8'hFF, 1'b1, 16'hFF81, c_et ? 7 : 8);
        retire8("s_127xm1");
        run8("u80xFF",   8'h80, 8'hFF, 1'b0, 16'h7F80, 8);

        // Backpressure in DONE with a competing request present
        for (int i = 0; i < 5; i++) begin
            a8 = 8'h03; b8 = 8'h03; s8 = 1'b0; iv8 = 1'b1;
            tick();
            check("bp_prod", p8,   16'h7F80);
            check("bp_rdy",  rdy8, 0);
            check("bp_ov",   ov8,  1);
        end
        iv8 = 1'b0;
        retire8("bp");
        check("bp_ov_after_retire",   ov8, 0);
        check("bp_prod_after_retire", p8,  16'h7F80);
        tick();
        check("bp_no_queued_op", rdy8, 1);

        // Reset during BUSY cycle 4 of 255x3
        a8 = 8'hFF; b8 = 8'h03; s8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy_rdy", rdy8, 1);
        check("rst_busy_ov",  ov8,  0);
        check("rst_busy_p",   p8,   16'h0000);
        run8("fresh2x3", 8'h02, 8'h03, 1'b0, 16'h0006, c_et ? 2 : 8);
        retire8("fresh2x3");

        // Early-termination vectors (full latency without the macro)
        run8("et3x7",   8'h03, 8'h07, 1'b0, 16'h0015, c_et ? 2 : 8);
        retire8("et3x7");
        run8("et0x200", 8'h00, 8'hC8, 1'b0, 16'h0000, c_et ? 1 : 8);
        retire8("et0x200");

        // Back-to-back on the wide instance
        a16 = 16'hFFFF; b16 = 16'hFFFF; s16 = 1'b0; or16 = 1'b1; iv16 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (rdy16) acc_cyc.push_back(c);
            if (ov16) check("b2b_prod", p16, 32'hFFFE0001);
            tick();
        end
        iv16 = 1'b0;
        check("b2b_n_accepts", (acc_cyc.size() >= 3), 1);
        if (acc_cyc.size() >= 3) begin
            check("b2b_gap0", acc_cyc[1] - acc_cyc[0], 6);
            check("b2b_gap1", acc_cyc[2] - acc_cyc[1], 6);
        end
        guard = 0;
        while (!rdy16 && guard < 20) begin
            tick();
            guard++;
        end
        check("b2b_drain", rdy16, 1);
        or16 = 1'b0;

        run16("s16_m2x1234", 16'hFFFE, 16'h1234, 1'b1, 32'hFFFFDB98, c_et ? 1 : 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
